// File: rtl/xlr8_lfsr_sched_if.sv
// Requester, seed-control and LFSR-core signals of xlr8_lfsr_sched.
// The slave modport is the scheduler; the master modport is the XB register side plus the core.
interface xlr8_lfsr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] rdata;
  logic [IDW-1:0]   grant_id;
  logic             seed_wr;
  logic [WIDTH-1:0] seed_in;
  logic             seed_busy;
  logic             free_run;
  logic             lfsr_enable;
  logic             lfsr_new_seed;
  logic [WIDTH-1:0] lfsr_seed;
  logic [WIDTH-1:0] lfsr_data;

  modport slave (
    input  req, seed_wr, seed_in, free_run, lfsr_data,
    output ack, rdata, grant_id, seed_busy, lfsr_enable, lfsr_new_seed, lfsr_seed
  );

  modport master (
    output req, seed_wr, seed_in, free_run, lfsr_data,
    input  ack, rdata, grant_id, seed_busy, lfsr_enable, lfsr_new_seed, lfsr_seed
  );
endinterface

// File: rtl/xlr8_lfsr_sched.sv
// Round-robin draw scheduler and seed sequencer for a shared alorium_lfsr core.
// NREQ may be 2..8.
//
// state | meaning
// IDLE  | arbitrate: pending seed first, then round-robin draw; optional free-run stepping
// SEED  | lfsr_new_seed high, core loads lfsr_seed
// STEP  | lfsr_enable high, core advances once for the granted requester
// CAPT  | core output holds the stepped word; captured into rdata at the closing edge
// ACK   | one-hot ack to the granted requester
module xlr8_lfsr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  xlr8_lfsr_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    STEP = 3'd2,
    CAPT = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand_idx;
  logic             win_found;
  logic             any_req;
  int               cand;

  logic             seed_take;
  logic             seed_bypass;
  logic             do_grant;
  logic             seed_pend;
  logic [WIDTH-1:0] seed_buf;
  logic [WIDTH-1:0] seed_fix;

  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] rdata_q;
  logic [IDW-1:0]   grant_id_q;
  logic [WIDTH-1:0] lfsr_seed_q;

  assign any_req  = |bus.req;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_fix = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    seed_take   = 1'b0;
    seed_bypass = 1'b0;
    do_grant    = 1'b0;
    case (state)
      IDLE: begin
        if (seed_pend) begin
          state_nxt = SEED;
          seed_take = 1'b1;
        end else if (bus.seed_wr) begin
          // Fresh write with nothing queued loads straight from seed_in.
          state_nxt   = SEED;
          seed_bypass = 1'b1;
        end else if (win_found) begin
          state_nxt = STEP;
          do_grant  = 1'b1;
        end
      end
      SEED:    state_nxt = IDLE;
      STEP:    state_nxt = CAPT;
      CAPT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q       <= '0;
      rdata_q     <= '0;
      grant_id_q  <= '0;
      last        <= IDW'(NREQ - 1);
      lfsr_seed_q <= '0;
      seed_pend   <= 1'b0;
      seed_buf    <= '0;
    end else begin
      ack_q <= '0;
      if (state == CAPT) begin
        ack_q   <= NREQ'(1) << grant_id_q;
        rdata_q <= bus.lfsr_data;
      end
      if (do_grant) begin
        last       <= win_idx;
        grant_id_q <= win_idx;
      end
      if (seed_take) begin
        lfsr_seed_q <= seed_buf;
      end else if (seed_bypass) begin
        lfsr_seed_q <= seed_fix;
      end
      if (bus.seed_wr) begin
        seed_buf <= seed_fix;
      end
      // A write landing on the load cycle keeps the newer value queued.
      if (seed_take) begin
        seed_pend <= bus.seed_wr;
      end else if (bus.seed_wr && !seed_bypass) begin
        seed_pend <= 1'b1;
      end
    end
  end

  assign bus.ack           = ack_q;
  assign bus.rdata         = rdata_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.lfsr_seed     = lfsr_seed_q;
  assign bus.lfsr_new_seed = (state == SEED);
  assign bus.seed_busy     = seed_pend | (state == SEED);
  assign bus.lfsr_enable   = (state == STEP) |
                             ((state == IDLE) & bus.free_run & ~seed_pend & ~any_req);
endmodule

// File: tb/tb_xlr8_lfsr_sched.sv
// Scoreboard bench for xlr8_lfsr_sched with a behavioural LFSR core
// (x^8+x^6+x^5+x^4+1, shift left, resets to 8'h01).
module tb_xlr8_lfsr_sched;
  logic clk;
  logic rst;

  xlr8_lfsr_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

  xlr8_lfsr_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         ns_cnt = 0;
  logic [7:0] seen_seed = 8'h00;
  logic [7:0] core;

  function automatic logic [7:0] lfsr_step(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) core <= 8'h01;
    else if (bus.lfsr_new_seed) core <= bus.lfsr_seed;
    else if (bus.lfsr_enable) core <= lfsr_step(core);
  end
  assign bus.lfsr_data = core;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every ack is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.lfsr_new_seed) begin
      ns_cnt++;
      seen_seed = bus.lfsr_seed;
    end
    if (!rst && bus.ack != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_onehot", 32'(bus.ack), 32'd1 << e.id);
        chk("rdata", 32'(bus.rdata), 32'(e.data));
        chk("grant_id", 32'(bus.grant_id), 32'(e.id));
      end
    end
  end

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (bus.ack == 4'b0000 && n < 20);
    chk("ack_seen", 32'(|bus.ack), 32'd1);
  endtask

  task automatic draw(input int id, input logic [7:0] data, output int n);
    @(posedge clk);
    #1;
    bus.req[id] = 1'b1;
    push(id, data);
    wait_ack(n);
    bus.req[id] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'h0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
    chk({tag, "_lfsr_seed"}, 32'(bus.lfsr_seed), 32'h0);
    chk({tag, "_new_seed"}, 32'(bus.lfsr_new_seed), 32'h0);
    chk({tag, "_enable"}, 32'(bus.lfsr_enable), 32'h0);
    chk({tag, "_seed_busy"}, 32'(bus.seed_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int ns0;
    rst          = 1'b0;
    bus.req      = 4'b0000;
    bus.seed_wr  = 1'b0;
    bus.seed_in  = 8'h00;
    bus.free_run = 1'b0;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single draw from requester 2; core 01 -> 02.
    draw(2, 8'h02, n);
    chk("latency_req2", 32'(n), 32'd3);

    // Seed 5A, then draw from requester 0: 5A -> B4.
    ns0 = ns_cnt;
    @(posedge clk); #1;
    bus.seed_wr = 1'b1;
    bus.seed_in = 8'h5A;
    @(posedge clk); #1;
    bus.seed_wr = 1'b0;
    @(negedge clk);
    chk("seed5a_new_seed", 32'(bus.lfsr_new_seed), 32'd1);
    chk("seed5a_lfsr_seed", 32'(bus.lfsr_seed), 32'h5A);
    chk("seed5a_busy_high", 32'(bus.seed_busy), 32'd1);
    @(negedge clk);
    chk("seed5a_new_seed_low", 32'(bus.lfsr_new_seed), 32'd0);
    chk("seed5a_busy_low", 32'(bus.seed_busy), 32'd0);
    chk("seed5a_pulses", 32'(ns_cnt - ns0), 32'd1);
    draw(0, 8'hB4, n);

    // Zero seed becomes 01; draw from requester 3 gives 02.
    @(posedge clk); #1;
    bus.seed_wr = 1'b1;
    bus.seed_in = 8'h00;
    @(posedge clk); #1;
    bus.seed_wr = 1'b0;
    @(negedge clk);
    chk("seed00_lfsr_seed", 32'(bus.lfsr_seed), 32'h01);
    draw(3, 8'h02, n);

    // Seeds 11 then 22 during a draw by requester 1 (02 -> 04); only 22 loads, after ACK.
    ns0 = ns_cnt;
    @(posedge clk); #1;
    bus.req[1] = 1'b1;
    push(1, 8'h04);
    @(posedge clk); #1;
    bus.seed_wr = 1'b1;
    bus.seed_in = 8'h11;
    @(posedge clk); #1;
    bus.seed_in = 8'h22;
    @(posedge clk); #1;
    bus.seed_wr = 1'b0;
    bus.req[1]  = 1'b0;
    chk("inflight_ack", 32'(bus.ack), 32'h2);
    chk("inflight_busy", 32'(bus.seed_busy), 32'd1);
    chk("inflight_no_load_yet", 32'(ns_cnt - ns0), 32'd0);
    repeat (4) @(negedge clk);
    chk("inflight_pulses", 32'(ns_cnt - ns0), 32'd1);
    chk("inflight_seed", 32'(seen_seed), 32'h22);
    chk("inflight_busy_low", 32'(bus.seed_busy), 32'd0);
    draw(2, 8'h45, n);

    // Free-run with no requests: enable every idle cycle.
    @(posedge clk); #1;
    bus.free_run = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.lfsr_enable) cnt++;
    end
    chk("freerun_idle_enable", 32'(cnt), 32'd6);

    // Free-run with seed 80 and a request from 3: seed first, one step only (80 -> 01).
    @(posedge clk); #1;
    bus.seed_wr = 1'b1;
    bus.seed_in = 8'h80;
    bus.req[3]  = 1'b1;
    push(3, 8'h01);
    @(posedge clk); #1;
    bus.seed_wr = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.lfsr_enable) cnt++;
    end
    chk("freerun_draw_ack", 32'(bus.ack), 32'h8);
    bus.req[3]   = 1'b0;
    bus.free_run = 1'b0;
    chk("freerun_draw_enable", 32'(cnt), 32'd1);

    // Reset during CAPT of a draw by requester 1: no ack, immediate reset values.
    @(posedge clk); #1;
    bus.req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_capt");
    repeat (2) begin
      @(negedge clk);
      chk("rst_capt_no_ack", 32'(bus.ack), 32'h0);
    end
    push(1, 8'h02);
    rst = 1'b0;
    wait_ack(n);
    chk("post_rst_latency", 32'(n), 32'd3);
    bus.req[1] = 1'b0;

    // Fresh reset, all four held: order 0,1,2,3,0 at one ack per 4 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.req = 4'b1111;
    push(0, 8'h02);
    push(1, 8'h04);
    push(2, 8'h08);
    push(3, 8'h11);
    push(0, 8'h23);
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      if (k == 0) chk("rr_first_latency", 32'(n), 32'd3);
      else        chk("rr_ack_spacing", 32'(n), 32'd4);
    end
    bus.req = 4'b0000;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xlr8_lfsr_sched.md
# xlr8_lfsr_sched

Round-robin scheduler that shares one `alorium_lfsr` core between `NREQ` requesters and sequences its seed-load and step controls. Each requester asks for one fresh random word with a req/ack handshake. Seed writes are queued and applied to the core between draws. An optional free-run mode steps the core during idle cycles. Sits between the XB register logic and the LFSR core, replacing direct `enable`/`new_seed` drive.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: LFSR/data width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  NREQ  per-requester draw request; level, held until ack.
- `ack`  out  NREQ  one-hot, one-cycle pulse; `rdata` valid with it.
- `rdata`  out  WIDTH  drawn word, registered, held until next ack.
- `grant_id`  out  $clog2(NREQ)  index of last granted requester.
- `seed_wr`  in  1  one-cycle strobe; capture `seed_in`.
- `seed_in`  in  WIDTH  seed value.
- `seed_busy`  out  1  seed pending or being loaded.
- `free_run`  in  1  step core on idle cycles.
- `lfsr_enable`  out  1  to core `enable`.
- `lfsr_new_seed`  out  1  to core `new_seed`.
- `lfsr_seed`  out  WIDTH  to core `seed`, registered.
- `lfsr_data`  in  WIDTH  from core `lfsr_data`.

## Operation
- FSM states: IDLE, SEED, STEP, CAPT, ACK.
- In IDLE, seed has priority: if `seed_pend`, go to SEED and load `lfsr_seed` from `seed_buf`. Otherwise, if any `req` is high, go to STEP and register the winner in `gnt`/`grant_id`. Otherwise stay in IDLE.
- SEED: `lfsr_new_seed`=1 for exactly one cycle, then go to IDLE.
- STEP: `lfsr_enable`=1 for exactly one cycle, then go to CAPT.
- CAPT: at the closing edge, `rdata`<=`lfsr_data` and `ack[gnt]`<=1; go to ACK.
- ACK: `ack` is high this cycle only, then go to IDLE.
- Round-robin:
  - Search starts at `last+1` mod NREQ; `last` updates to the winner on each grant.
  - Reset value of `last` is NREQ-1, so req0 wins first.
  - Any continuously asserted request is granted within NREQ grants.
- Seed buffering:
  - `seed_wr` writes `seed_buf` and sets `seed_pend` in any state; the last write wins.
  - `seed_pend` clears on IDLE->SEED unless `seed_wr` is high in that same cycle, in which case it stays set.
  - A `seed_in` of all-zeros is stored as `{WIDTH-1{0},1}` to avoid LFSR lockup.
- `seed_busy` = `seed_pend` | (state==SEED).
- Free-run: in IDLE with `free_run`=1, no `seed_pend` and no `req` set, `lfsr_enable`=1 (combinational). Otherwise `lfsr_enable` is high only in STEP.
- Requesters must drop `req` in the cycle after `ack`. A `req` still high in IDLE is a new request.
- A `req` deasserted before its grant is simply not granted. A `req` deasserted after its grant still completes and acks.

## Timing
- Reset (async, immediate) values:
  - state=IDLE.
  - `ack`=0, `rdata`=0, `grant_id`=0, `lfsr_seed`=0.
  - `lfsr_new_seed`=0, `lfsr_enable`=0.
  - `seed_pend`=0, `seed_buf`=0, `last`=NREQ-1.
- Reset mid-transaction aborts it with no ack.
- Draw latency: `req` sampled high at edge E0 in IDLE -> STEP in cycle after E0 -> `ack` high in the third cycle after E0. The delivered word is the core value after exactly one step.
- Seed latency: `seed_wr` at E0 with IDLE and no draw in flight -> `lfsr_new_seed` high in the cycle after E0. The first draw after that returns the successor of the loaded seed.
- Throughput: one draw per 4 cycles. A seed load costs 2 cycles (SEED + return to IDLE).
- A simultaneous `seed_wr` and `req` in IDLE gives seed first, then the draw.
- `lfsr_seed` is stable for the whole SEED cycle and holds its value until the next load.

## Test plan
- Reset, then a single `req[2]` pulse-held: `ack`=4'b0100 exactly 3 cycles after `req` is sampled, `rdata`=core step of its current state, `grant_id`=2.
- Load seed 8'h5A with `seed_wr`, then `req[0]`: `lfsr_new_seed` pulses once with `lfsr_seed`=8'h5A, `seed_busy` falls, and `rdata` = next LFSR value after 8'h5A.
- All four `req` held continuously: grant order 0,1,2,3,0, with one ack every 4 cycles and no requester skipped.
- `seed_wr` of 8'h00: `lfsr_seed` = 8'h01.
- `seed_wr` 8'h11 then 8'h22 during an in-flight draw: only 8'h22 is loaded, after ACK.
- `free_run`=1 with no requests: `lfsr_enable` is high every IDLE cycle.
- `free_run`=1 with a `req`: stepping halts for the draw, and `lfsr_enable` is high only once (STEP) during that draw.
- Assert `rst` during CAPT: no `ack` is issued, all outputs go to their reset values immediately, and a subsequent `req[1]` is granted normally.
